// File: rtl/joy2trackball.sv
// joy2trackball: joystick/mouse to wrapping trackball position counters with acceleration and mouse backlog.
// Optional quadrature outputs enabled by defining JOY2TRACKBALL_QUAD_OUT_EN.
module joy2trackball #(
    parameter int AXES        = 2,
    parameter int CNT_W       = 8,
    parameter int RATE_DIV    = 16384,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 8,
    parameter int PEND_W      = 10
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [AXES-1:0]       joy_pos,
    input  logic [AXES-1:0]       joy_neg,
    input  logic                  mouse_stb,
    input  logic [AXES*8-1:0]     mouse_dx,
    output logic [AXES*CNT_W-1:0] count,
    output logic                  tick,
    output logic [AXES-1:0]       quad_a,
    output logic [AXES-1:0]       quad_b
);
    localparam int DW = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
    localparam int HW = $clog2(ACCEL_TICKS) + 1;
    localparam int SW = ((PEND_W > 8) ? PEND_W : 8) + 2;
    localparam logic signed [SW-1:0] PMAX = SW'((1 << (PEND_W - 1)) - 1);
    localparam logic signed [SW-1:0] SMAX = SW'(MAX_SPEED);

    logic [DW-1:0] div_q;
    logic          tick_q;
    logic          wrap;

    // wrap is the internal step instant; tick and counts become visible one cycle later together
    assign wrap = div_q == DW'(RATE_DIV - 1);
    assign tick = tick_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= wrap ? '0 : div_q + 1'b1;
            tick_q <= wrap;
        end
    end

    for (genvar g = 0; g < AXES; g++) begin : g_axis
        logic [CNT_W-1:0]         count_q, count_d;
        logic [3:0]               speed_q, speed_d;
        logic [HW-1:0]            hold_q, hold_d;
        logic signed [1:0]        dir, prev_q, prev_d;
        logic signed [PEND_W-1:0] pend_q, pend_d;
        logic signed [SW-1:0]     pend_x, dx_x, drain, sum;
        logic signed [5:0]        spd, step;
        logic                     same, bump;

        always_comb begin
            dir     = (joy_pos[g] & ~joy_neg[g]) ? 2'sd1 : (joy_neg[g] & ~joy_pos[g]) ? -2'sd1 : 2'sd0;
            pend_x  = SW'(pend_q);
            dx_x    = mouse_stb ? SW'($signed(mouse_dx[8*g +: 8])) : '0;
            drain   = !wrap ? '0 : (pend_x > SMAX) ? SMAX : (pend_x < -SMAX) ? -SMAX : pend_x;
            sum     = pend_x + dx_x - drain;
            pend_d  = (sum > PMAX) ? PEND_W'(PMAX) : (sum < -PMAX) ? PEND_W'(-PMAX) : PEND_W'(sum);
            same    = (dir != 2'sd0) && (dir == prev_q);
            bump    = same && (int'(hold_q) + 1 >= ACCEL_TICKS - 1);
            hold_d  = !wrap ? hold_q : (!same || bump) ? '0 : hold_q + 1'b1;
            speed_d = !wrap ? speed_q : !same ? 4'd1 :
                      (bump && speed_q < 4'(MAX_SPEED)) ? speed_q + 4'd1 : speed_q;
            prev_d  = wrap ? dir : prev_q;
            spd     = $signed({2'b00, speed_q});
            step    = ((dir > 0) ? spd : (dir < 0) ? -spd : 6'sd0) + 6'(drain);
            count_d = wrap ? count_q + CNT_W'(step) : count_q;
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                count_q <= '0;
                speed_q <= 4'd1;
                hold_q  <= '0;
                prev_q  <= 2'sd0;
                pend_q  <= '0;
            end else begin
                count_q <= count_d;
                speed_q <= speed_d;
                hold_q  <= hold_d;
                prev_q  <= prev_d;
                pend_q  <= pend_d;
            end
        end

        assign count[CNT_W*g +: CNT_W] = count_q;

`ifdef JOY2TRACKBALL_QUAD_OUT_EN
        logic [CNT_W-1:0] qpos_q, qpos_d, diff;

        // the most negative difference counts as negative, so a half-turn gap chases downward
        always_comb begin
            diff   = count_q - qpos_q;
            qpos_d = (diff == '0) ? qpos_q : diff[CNT_W-1] ? qpos_q - 1'b1 : qpos_q + 1'b1;
        end

        always_ff @(posedge clk_sys) begin
            if (reset) qpos_q <= '0;
            else       qpos_q <= qpos_d;
        end

        assign quad_a[g] = qpos_q[1];
        assign quad_b[g] = qpos_q[1] ^ qpos_q[0];
`else
        assign quad_a[g] = 1'b0;
        assign quad_b[g] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_joy2trackball.sv
// tb_joy2trackball: directed checks of joy2trackball with RATE_DIV=4, two 8-bit axes.
module tb_joy2trackball;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  joy_pos = '0, joy_neg = '0;
    logic        mouse_stb = 1'b0;
    logic [15:0] mouse_dx = '0;
    logic [15:0] count;
    logic        tick;
    logic [1:0]  quad_a, quad_b;
    int          tests = 0, fails = 0;

    joy2trackball #(.AXES(2), .CNT_W(8), .RATE_DIV(4), .MAX_SPEED(4), .ACCEL_TICKS(8), .PEND_W(10)) dut (
        .clk_sys(clk_sys), .reset(reset), .joy_pos(joy_pos), .joy_neg(joy_neg),
        .mouse_stb(mouse_stb), .mouse_dx(mouse_dx), .count(count), .tick(tick),
        .quad_a(quad_a), .quad_b(quad_b)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b1; joy_pos = '0; joy_neg = '0; mouse_stb = 1'b0; mouse_dx = '0;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!tick && n < 64);
        tests++;
        if (tick !== 1'b1) begin
            fails++;
            $display("FAIL tick_timeout: tick=%b after %0d cycles, required 1", tick, n);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        tests++;
        if (count !== 16'h0) begin fails++; $display("FAIL reset_count: got %h required 0000", count); end
        tests++;
        if (tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b required 0", tick); end
        tests++;
        if ({quad_a, quad_b} !== 4'b0) begin fails++; $display("FAIL reset_quad: got %b required 0000", {quad_a, quad_b}); end
        reset = 1'b0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!tick && n < 64);
        tests++;
        if (n !== 4) begin fails++; $display("FAIL first_tick_latency: got %0d cycles required 4", n); end
        @(negedge clk_sys);
        tests++;
        if (tick !== 1'b0) begin fails++; $display("FAIL tick_width: got %b required 0", tick); end
        n = 1;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!tick && n < 64);
        tests++;
        if (n !== 4) begin fails++; $display("FAIL tick_period: got %0d cycles required 4", n); end
    endtask

    task automatic test_joy_accel();
        int e = 0;
        do_reset();
        joy_pos = 2'b01;
        for (int k = 1; k <= 36; k++) begin
            wait_tick();
            e += (k <= 8) ? 1 : (k <= 15) ? 2 : (k <= 22) ? 3 : 4;
            tests++;
            if (count[7:0] !== 8'(e)) begin
                fails++;
                $display("FAIL joy_accel tick %0d: count0=%0d required %0d", k, count[7:0], e);
            end
        end
        tests++;
        if (count[15:8] !== 8'd0) begin fails++; $display("FAIL axis1_idle: count1=%0d required 0", count[15:8]); end
        joy_pos = 2'b00;
        wait_tick();
        tests++;
        if (count[7:0] !== 8'd99) begin fails++; $display("FAIL joy_release: count0=%0d required 99", count[7:0]); end
        joy_pos = 2'b01;
        wait_tick();
        tests++;
        if (count[7:0] !== 8'd100) begin fails++; $display("FAIL joy_repress: count0=%0d required 100", count[7:0]); end
        wait_tick();
        tests++;
        if (count[7:0] !== 8'd101) begin fails++; $display("FAIL joy_repress2: count0=%0d required 101", count[7:0]); end
    endtask

    task automatic test_opposed_and_wrap();
        do_reset();
        joy_pos = 2'b10; joy_neg = 2'b10;
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            tests++;
            if (count[15:8] !== 8'd0) begin fails++; $display("FAIL opposed tick %0d: count1=%0d required 0", k, count[15:8]); end
        end
        joy_pos = 2'b00;
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            tests++;
            if (count[15:8] !== 8'(255 - k)) begin
                fails++;
                $display("FAIL neg_wrap tick %0d: count1=%0d required %0d", k, count[15:8], 255 - k);
            end
        end
    endtask

    task automatic test_mouse();
        logic [7:0] e0 [4] = '{8'd4, 8'd8, 8'd10, 8'd10};
        logic [7:0] e1 [4] = '{8'd252, 8'd250, 8'd250, 8'd250};
        do_reset();
        mouse_dx = {8'hFA, 8'd10};
        mouse_stb = 1'b1;
        @(negedge clk_sys);
        mouse_stb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_tick();
            tests++;
            if (count !== {e1[k], e0[k]}) begin
                fails++;
                $display("FAIL mouse_drain tick %0d: count1=%0d count0=%0d required %0d %0d", k, count[15:8], count[7:0], e1[k], e0[k]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mouse_dx = {8'd0, 8'd127};
        mouse_stb = 1'b1;
        repeat (200) @(posedge clk_sys);
        @(negedge clk_sys);
        mouse_stb = 1'b0;
        tests++;
        if (tick !== 1'b1) begin fails++; $display("FAIL sat_tick_align: tick=%b required 1", tick); end
        tests++;
        if (count[7:0] !== 8'd200) begin fails++; $display("FAIL sat_during: count0=%0d required 200", count[7:0]); end
        repeat (127) wait_tick();
        tests++;
        if (count[7:0] !== 8'd196) begin fails++; $display("FAIL sat_drain: count0=%0d required 196", count[7:0]); end
        wait_tick();
        tests++;
        if (count[7:0] !== 8'd199) begin fails++; $display("FAIL sat_last: count0=%0d required 199", count[7:0]); end
        wait_tick();
        tests++;
        if (count !== {8'd0, 8'd199}) begin fails++; $display("FAIL sat_empty: count=%h required 00c7", count); end
    endtask

    task automatic test_coincident();
        do_reset();
        mouse_dx = {8'd0, 8'd6};
        mouse_stb = 1'b1;
        @(negedge clk_sys);
        mouse_stb = 1'b0;
        wait_tick();
        tests++;
        if (count[7:0] !== 8'd4) begin fails++; $display("FAIL coinc_first: count0=%0d required 4", count[7:0]); end
        repeat (3) @(negedge clk_sys);
        mouse_dx = {8'd0, 8'd5};
        mouse_stb = 1'b1;
        @(negedge clk_sys);
        mouse_stb = 1'b0;
        tests++;
        if ({tick, count[7:0]} !== {1'b1, 8'd6}) begin
            fails++;
            $display("FAIL coinc_tick: tick=%b count0=%0d required 1 6", tick, count[7:0]);
        end
        wait_tick();
        tests++;
        if (count[7:0] !== 8'd10) begin fails++; $display("FAIL coinc_after: count0=%0d required 10", count[7:0]); end
        wait_tick();
        tests++;
        if (count[7:0] !== 8'd11) begin fails++; $display("FAIL coinc_rest: count0=%0d required 11", count[7:0]); end
        wait_tick();
        tests++;
        if (count[7:0] !== 8'd11) begin fails++; $display("FAIL coinc_stop: count0=%0d required 11", count[7:0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        joy_pos = 2'b01;
        mouse_dx = {8'd0, 8'd100};
        mouse_stb = 1'b1;
        @(negedge clk_sys);
        mouse_stb = 1'b0;
        repeat (3) wait_tick();
        reset = 1'b1;
        joy_pos = 2'b00;
        @(negedge clk_sys);
        tests++;
        if ({tick, count} !== 17'h0) begin fails++; $display("FAIL mid_reset: tick=%b count=%h required 0 0000", tick, count); end
        reset = 1'b0;
        repeat (2) wait_tick();
        tests++;
        if (count !== 16'h0) begin fails++; $display("FAIL backlog_discard: count=%h required 0000", count); end
        joy_pos = 2'b01;
        wait_tick();
        tests++;
        if (count[7:0] !== 8'd1) begin fails++; $display("FAIL speed_discard: count0=%0d required 1", count[7:0]); end
    endtask

`ifdef JOY2TRACKBALL_QUAD_OUT_EN
    task automatic test_quad();
        logic [1:0] eq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        do_reset();
        mouse_dx = {8'd0, 8'd3};
        mouse_stb = 1'b1;
        @(negedge clk_sys);
        mouse_stb = 1'b0;
        wait_tick();
        tests++;
        if (count[7:0] !== 8'd3) begin fails++; $display("FAIL quad_count: count0=%0d required 3", count[7:0]); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({quad_a[0], quad_b[0]} !== eq[k]) begin
                fails++;
                $display("FAIL quad_seq step %0d: ab=%b required %b", k, {quad_a[0], quad_b[0]}, eq[k]);
            end
            if (k < 3) @(negedge clk_sys);
        end
        @(negedge clk_sys);
        tests++;
        if ({quad_a[0], quad_b[0]} !== 2'b10) begin fails++; $display("FAIL quad_hold: ab=%b required 10", {quad_a[0], quad_b[0]}); end
        mouse_stb = 1'b1;
        @(negedge clk_sys);
        mouse_stb = 1'b0;
        wait_tick();
        @(negedge clk_sys);
        tests++;
        if ({quad_a[0], quad_b[0]} !== 2'b00) begin fails++; $display("FAIL quad_chase: ab=%b required 00", {quad_a[0], quad_b[0]}); end
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        tests++;
        if ({count, quad_a, quad_b} !== 20'h0) begin
            fails++;
            $display("FAIL quad_reset: count=%h quad=%b required 0000 0000", count, {quad_a, quad_b});
        end
    endtask
`else
    task automatic test_quad();
        do_reset();
        joy_pos = 2'b11;
        for (int k = 0; k < 6; k++) begin
            wait_tick();
            @(negedge clk_sys);
            tests++;
            if ({quad_a, quad_b} !== 4'b0) begin fails++; $display("FAIL quad_tied: quad=%b required 0000", {quad_a, quad_b}); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_joy_accel();
        test_opposed_and_wrap();
        test_mouse();
        test_saturation();
        test_coincident();
        test_reset_mid();
        test_quad();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
